// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and
// the FSM state encoding used by serial_adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built as two cascaded half adders whose carries are
// merged by an OR. Used once by serial_adder for its bit-serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // First half adder: operand bits
    assign ha0_s = a ^ b;
    assign ha0_c = a & b;

    // Second half adder: partial sum with incoming carry
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;

    // Either half adder may produce the carry, never both
    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder. An accepted start captures both operands; the sum is then
// formed one bit per clock, LSB first, through a single full adder. After
// WIDTH processing edges the result and carry-out are registered to the
// outputs and done pulses for one cycle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit so the counter can reach WIDTH without wrapping
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Next-state logic: operand capture, per-bit shift, and result hand-off
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // DONE lasts exactly one cycle, so done can be decoded from the state
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8: directed vector table,
// hand-written multi-cycle sequences, and random operands against a + b.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] hist [int];

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [6];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for done; returns cycles since the accept edge, or -1
    task automatic wait_done(input int acc, output int lat);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = done ? (cyc - acc) : -1;
    endtask

    // One complete addition started from idle
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] s, output logic c, output int lat,
                          output int busy_n, output logic stable, output logic pulse_after);
        int acc;
        int n;
        logic [7:0] prev;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        acc = cyc + 1;
        prev = sum;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        busy_n = 0; stable = 1'b1; n = 0;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            if (sum !== prev) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        lat = done ? (cyc - acc) : -1;
        s = sum; c = cout;
        @(negedge clk);
        pulse_after = done;
    endtask

    initial begin
        logic [7:0] s;
        logic       c;
        int         lat;
        int         bn;
        logic       st;
        logic       pa;
        int         acc;
        int         got;
        int         last_done;
        int         n;
        logic       saw_done;
        logic [8:0] exp9;
        logic [7:0] ra, rb;

        vecs[0] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};

        // Reset state
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, s, c, lat, bn, st, pa);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 8);
            check($sformatf("vec%0d_sum_stable_in_run", i), 32'(st), 1);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(pa), 0);
        end

        // Start during RUN is ignored; operands changed after accept do not matter
        @(negedge clk);
        a = 8'h0F; b = 8'h01; start = 1'b1; acc = cyc + 1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk); start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done(acc, lat);
        check("ignore_start_sum", 32'(sum), 32'h10);
        check("ignore_start_cout", 32'(cout), 0);
        check("ignore_start_latency", 32'(lat), 8);
        @(negedge clk);
        check("ignore_start_no_rerun", 32'(busy), 0);

        // start held high: back-to-back results every WIDTH+1 cycles
        @(negedge clk);
        start = 1'b1; got = 0; last_done = -1; n = 0;
        while (got < 5 && n < 80) begin
            a = 8'($urandom); b = 8'($urandom);
            hist[cyc + 1] = {a, b};
            @(negedge clk);
            n++;
            if (done) begin
                acc = cyc - W;
                if (hist.exists(acc)) begin
                    exp9 = {1'b0, hist[acc][15:8]} + {1'b0, hist[acc][7:0]};
                    check($sformatf("b2b%0d_result", got), 32'({cout, sum}), 32'(exp9));
                end else begin
                    check($sformatf("b2b%0d_accept_edge", got), 0, 1);
                end
                if (last_done >= 0)
                    check($sformatf("b2b%0d_period", got), 32'(cyc - last_done), W + 1);
                last_done = cyc;
                got++;
            end
        end
        start = 1'b0;
        check("b2b_result_count", 32'(got), 5);
        repeat (2) @(negedge clk);

        // Reset in the middle of an operation
        run_op(8'h33, 8'h44, s, c, lat, bn, st, pa);
        check("pre_reset_sum", 32'(s), 32'h77);
        @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_sum", 32'(sum), 0);
        check("midrun_reset_cout", 32'(cout), 0);
        check("midrun_reset_busy", 32'(busy), 0);
        check("midrun_reset_done", 32'(done), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (i == 2) rst_n = 1'b1;
        end
        check("midrun_reset_no_done", 32'(saw_done), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; a = 8'h12; b = 8'h34; start = 1'b1; acc = cyc + 1;
        @(negedge clk); start = 1'b0;
        wait_done(acc, lat);
        check("after_reset_sum", 32'(sum), 32'h46);
        check("after_reset_cout", 32'(cout), 0);
        check("after_reset_latency", 32'(lat), 8);

        // Random operands against plain a + b
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, s, c, lat, bn, st, pa);
            check($sformatf("rand%0d_%02h_%02h", i, ra, rb), 32'({c, s}), 32'(exp9));
            if (lat != W) check($sformatf("rand%0d_latency", i), 32'(lat), W);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
